// File: rtl/chi_txn_tracker_if.sv
// Passive view of the CHI TXREQ and RXRSP channels.
// master: whatever drives the link (the bench, or the real channel wires).
// slave : the tracker, which only observes the channels.
//   req_flitv/req_flit : TXREQ flit valid and payload
//   rsp_flitv/rsp_flit : RXRSP flit valid and payload
interface chi_txn_tracker_if #(
  parameter int unsigned REQ_W = 154,
  parameter int unsigned RSP_W = 73
);
  logic             req_flitv;
  logic [REQ_W-1:0] req_flit;
  logic             rsp_flitv;
  logic [RSP_W-1:0] rsp_flit;

  modport master (output req_flitv, req_flit, rsp_flitv, rsp_flit);
  modport slave  (input  req_flitv, req_flit, rsp_flitv, rsp_flit);
endinterface

// File: rtl/chi_txn_tracker.sv
// CHI RN-side transaction tracker. Records each TXREQ in a DEPTH-entry table
// keyed by (SrcID, TxnID) and retires it on a matching Comp/CompDBIDResp/RetryAck.
// Flags duplicates, overflow, orphan completions and per-entry timeout.
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   flit_if (slave)   : observed TXREQ / RXRSP channels
//   clear_err_i       : synchronous clear of sticky error flags and timeout_txnid
//   outstanding_o     : live entry count, full_o when it equals DEPTH
//   retire_*_o        : one-cycle retirement report with TxnID and latency
//   err_*_o           : sticky error flags, timeout_txnid_o is first timed-out TxnID
module chi_txn_tracker #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned NODEID_W = 11,
  parameter int unsigned TXNID_W  = 12,
  parameter int unsigned REQ_W    = 154,
  parameter int unsigned RSP_W    = 73,
  parameter int unsigned TIMEOUT  = 1024,
  parameter int unsigned AGE_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  chi_txn_tracker_if.slave         flit_if,
  input  logic                     clear_err_i,
  output logic [$clog2(DEPTH):0]   outstanding_o,
  output logic                     full_o,
  output logic                     retire_v_o,
  output logic [TXNID_W-1:0]       retire_txnid_o,
  output logic [AGE_W-1:0]         retire_age_o,
  output logic                     err_overflow_o,
  output logic                     err_dup_o,
  output logic                     err_orphan_o,
  output logic                     err_timeout_o,
  output logic [TXNID_W-1:0]       timeout_txnid_o
);
  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned CntW = IdxW + 1;
  localparam logic [AGE_W:0] TimeoutVal = (AGE_W+1)'(TIMEOUT);

  // Flit field extraction
  logic [REQ_W-1:0]    req_flit;
  logic [RSP_W-1:0]    rsp_flit;
  logic [NODEID_W-1:0] req_src, rsp_tgt;
  logic [TXNID_W-1:0]  req_txn, rsp_txn;
  logic [4:0]          rsp_op;
  logic                unused_flit_bits;

  assign req_flit = flit_if.req_flit;
  assign rsp_flit = flit_if.rsp_flit;
  assign req_src  = req_flit[15 +: NODEID_W];
  assign req_txn  = req_flit[26 +: TXNID_W];
  assign rsp_tgt  = rsp_flit[4 +: NODEID_W];
  assign rsp_txn  = rsp_flit[26 +: TXNID_W];
  assign rsp_op   = rsp_flit[42:38];
  assign unused_flit_bits = ^{req_flit[REQ_W-1:26+TXNID_W], req_flit[14:0],
                              rsp_flit[RSP_W-1:43], rsp_flit[25:4+NODEID_W], rsp_flit[3:0]};

  // Table state
  logic [DEPTH-1:0]    valid_q, valid_d, tflag_q, tflag_d;
  logic [NODEID_W-1:0] srcid_q [DEPTH];
  logic [NODEID_W-1:0] srcid_d [DEPTH];
  logic [TXNID_W-1:0]  txnid_q [DEPTH];
  logic [TXNID_W-1:0]  txnid_d [DEPTH];
  logic [AGE_W-1:0]    age_q   [DEPTH];
  logic [AGE_W-1:0]    age_d   [DEPTH];

  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               full_q, full_d;
  logic               retire_v_q, retire_v_d;
  logic [TXNID_W-1:0] retire_txnid_q, retire_txnid_d;
  logic [AGE_W-1:0]   retire_age_q, retire_age_d;
  logic               err_overflow_q, err_overflow_d, err_dup_q, err_dup_d;
  logic               err_orphan_q, err_orphan_d, err_timeout_q, err_timeout_d;
  logic [TXNID_W-1:0] timeout_txnid_q, timeout_txnid_d;

  logic            dup_hit, free_found, rsp_hit, is_comp, do_alloc, do_retire, to_any;
  logic [IdxW-1:0] free_idx, rsp_idx, to_idx;

  // Lookups, all against the pre-edge table
  always_comb begin
    dup_hit    = 1'b0;
    free_found = 1'b0;
    free_idx   = '0;
    rsp_hit    = 1'b0;
    rsp_idx    = '0;
    to_any     = 1'b0;
    to_idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && srcid_q[i] == req_src && txnid_q[i] == req_txn) dup_hit = 1'b1;
      if (!valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IdxW'(i);
      end
      if (valid_q[i] && srcid_q[i] == rsp_tgt && txnid_q[i] == rsp_txn) begin
        rsp_hit = 1'b1;
        rsp_idx = IdxW'(i);
      end
      // Lowest index wins when several entries cross on the same edge
      if (valid_q[i] && !tflag_q[i] && !to_any &&
          ({1'b0, age_q[i]} + {{AGE_W{1'b0}}, 1'b1}) == TimeoutVal) begin
        to_any = 1'b1;
        to_idx = IdxW'(i);
      end
    end
  end

  assign is_comp   = flit_if.rsp_flitv && (rsp_op inside {5'h03, 5'h04, 5'h05});
  // Not full implies a free entry exists
  assign do_alloc  = flit_if.req_flitv && !dup_hit && !full_q;
  assign do_retire = is_comp && rsp_hit;

  // Table next state
  always_comb begin
    valid_d = valid_q;
    tflag_d = tflag_q;
    for (int i = 0; i < DEPTH; i++) begin
      srcid_d[i] = srcid_q[i];
      txnid_d[i] = txnid_q[i];
      age_d[i]   = age_q[i];
      if (valid_q[i]) begin
        if (age_q[i] != '1) age_d[i] = age_q[i] + AGE_W'(1);
        if (!tflag_q[i] && ({1'b0, age_q[i]} + {{AGE_W{1'b0}}, 1'b1}) == TimeoutVal) begin
          tflag_d[i] = 1'b1;
        end
      end
      if (do_retire && rsp_idx == IdxW'(i)) valid_d[i] = 1'b0;
      // Free slot and retiring slot can never coincide
      if (do_alloc && free_idx == IdxW'(i)) begin
        valid_d[i] = 1'b1;
        srcid_d[i] = req_src;
        txnid_d[i] = req_txn;
        age_d[i]   = '0;
        tflag_d[i] = 1'b0;
      end
    end
  end

  // Counters, reports and sticky flags
  always_comb begin
    cnt_d          = cnt_q + CntW'(do_alloc) - CntW'(do_retire);
    full_d         = (cnt_d == CntW'(DEPTH));
    retire_v_d     = do_retire;
    retire_txnid_d = retire_txnid_q;
    retire_age_d   = retire_age_q;
    if (do_retire) begin
      retire_txnid_d = txnid_q[rsp_idx];
      retire_age_d   = (age_q[rsp_idx] == '1) ? '1 : age_q[rsp_idx] + AGE_W'(1);
    end
    // An event in the clear cycle still sets its flag
    err_dup_d      = (err_dup_q && !clear_err_i) || (flit_if.req_flitv && dup_hit);
    err_overflow_d = (err_overflow_q && !clear_err_i) ||
                     (flit_if.req_flitv && !dup_hit && full_q);
    err_orphan_d   = (err_orphan_q && !clear_err_i) || (is_comp && !rsp_hit);
    err_timeout_d  = (err_timeout_q && !clear_err_i) || to_any;
    timeout_txnid_d = timeout_txnid_q;
    if (to_any && (!err_timeout_q || clear_err_i)) timeout_txnid_d = txnid_q[to_idx];
    else if (clear_err_i)                          timeout_txnid_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q         <= '0;
      tflag_q         <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        srcid_q[i] <= '0;
        txnid_q[i] <= '0;
        age_q[i]   <= '0;
      end
      cnt_q           <= '0;
      full_q          <= 1'b0;
      retire_v_q      <= 1'b0;
      retire_txnid_q  <= '0;
      retire_age_q    <= '0;
      err_overflow_q  <= 1'b0;
      err_dup_q       <= 1'b0;
      err_orphan_q    <= 1'b0;
      err_timeout_q   <= 1'b0;
      timeout_txnid_q <= '0;
    end else begin
      valid_q         <= valid_d;
      tflag_q         <= tflag_d;
      for (int i = 0; i < DEPTH; i++) begin
        srcid_q[i] <= srcid_d[i];
        txnid_q[i] <= txnid_d[i];
        age_q[i]   <= age_d[i];
      end
      cnt_q           <= cnt_d;
      full_q          <= full_d;
      retire_v_q      <= retire_v_d;
      retire_txnid_q  <= retire_txnid_d;
      retire_age_q    <= retire_age_d;
      err_overflow_q  <= err_overflow_d;
      err_dup_q       <= err_dup_d;
      err_orphan_q    <= err_orphan_d;
      err_timeout_q   <= err_timeout_d;
      timeout_txnid_q <= timeout_txnid_d;
    end
  end

  assign outstanding_o   = cnt_q;
  assign full_o          = full_q;
  assign retire_v_o      = retire_v_q;
  assign retire_txnid_o  = retire_txnid_q;
  assign retire_age_o    = retire_age_q;
  assign err_overflow_o  = err_overflow_q;
  assign err_dup_o       = err_dup_q;
  assign err_orphan_o    = err_orphan_q;
  assign err_timeout_o   = err_timeout_q;
  assign timeout_txnid_o = timeout_txnid_q;
endmodule

// File: tb/tb_chi_txn_tracker.sv
module tb_chi_txn_tracker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear_err = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  chi_txn_tracker_if #(.REQ_W(154), .RSP_W(73)) flit_if ();

  // Main instance (TIMEOUT 1024) and a short-timeout instance on the same wires
  logic [4:0]  outstanding, t_outstanding;
  logic        full, retire_v, err_overflow, err_dup, err_orphan, err_timeout;
  logic [11:0] retire_txnid, timeout_txnid;
  logic [15:0] retire_age;
  logic        t_full, t_retire_v, t_err_overflow, t_err_dup, t_err_orphan, t_err_timeout;
  logic [11:0] t_retire_txnid, t_timeout_txnid;
  logic [15:0] t_retire_age;

  chi_txn_tracker #(.DEPTH(16), .TIMEOUT(1024)) dut (
    .clk(clk), .rst_n(rst_n), .flit_if(flit_if), .clear_err_i(clear_err),
    .outstanding_o(outstanding), .full_o(full), .retire_v_o(retire_v),
    .retire_txnid_o(retire_txnid), .retire_age_o(retire_age),
    .err_overflow_o(err_overflow), .err_dup_o(err_dup), .err_orphan_o(err_orphan),
    .err_timeout_o(err_timeout), .timeout_txnid_o(timeout_txnid)
  );

  chi_txn_tracker #(.DEPTH(16), .TIMEOUT(8)) dut_t (
    .clk(clk), .rst_n(rst_n), .flit_if(flit_if), .clear_err_i(clear_err),
    .outstanding_o(t_outstanding), .full_o(t_full), .retire_v_o(t_retire_v),
    .retire_txnid_o(t_retire_txnid), .retire_age_o(t_retire_age),
    .err_overflow_o(t_err_overflow), .err_dup_o(t_err_dup), .err_orphan_o(t_err_orphan),
    .err_timeout_o(t_err_timeout), .timeout_txnid_o(t_timeout_txnid)
  );

  // Stimulus helpers
  task automatic set_req(input logic [10:0] src, input logic [11:0] txn);
    flit_if.req_flitv = 1'b1;
    flit_if.req_flit = '0;
    flit_if.req_flit[25:15] = src;
    flit_if.req_flit[37:26] = txn;
  endtask

  task automatic set_rsp(input logic [10:0] tgt, input logic [11:0] txn, input logic [4:0] op);
    flit_if.rsp_flitv = 1'b1;
    flit_if.rsp_flit = '0;
    flit_if.rsp_flit[14:4]  = tgt;
    flit_if.rsp_flit[37:26] = txn;
    flit_if.rsp_flit[42:38] = op;
  endtask

  // Advance one edge; outputs are then stable for sampling, strobes drop.
  task automatic tick();
    @(posedge clk);
    #1;
    flit_if.req_flitv = 1'b0;
    flit_if.rsp_flitv = 1'b0;
    clear_err = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    flit_if.req_flitv = 1'b0;
    flit_if.rsp_flitv = 1'b0;
    flit_if.req_flit = '0;
    flit_if.rsp_flit = '0;
    #2;
    checks++;
    if (outstanding !== 5'd0 || full !== 1'b0 || retire_v !== 1'b0) begin
      failures++;
      $display("FAIL reset_state out=%0d full=%b rv=%b expected 0 0 0", outstanding, full, retire_v);
    end
    checks++;
    if ({err_overflow, err_dup, err_orphan, err_timeout} !== 4'b0 || timeout_txnid !== 12'd0) begin
      failures++;
      $display("FAIL reset_flags got=%b/%h expected 0000/000",
               {err_overflow, err_dup, err_orphan, err_timeout}, timeout_txnid);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    set_req(11'd5, 12'h012);
    tick();
    checks++;
    if (outstanding !== 5'd1) begin
      failures++;
      $display("FAIL basic_out1 got=%0d expected=1", outstanding);
    end
    ticks(9);
    set_rsp(11'd5, 12'h012, 5'h04);
    tick();
    checks++;
    if (retire_v !== 1'b1 || retire_txnid !== 12'h012 || retire_age !== 16'd10) begin
      failures++;
      $display("FAIL basic_retire got v=%b txn=%h age=%0d expected 1 012 10",
               retire_v, retire_txnid, retire_age);
    end
    checks++;
    if (outstanding !== 5'd0 || {err_overflow, err_dup, err_orphan, err_timeout} !== 4'b0) begin
      failures++;
      $display("FAIL basic_after out=%0d errs=%b expected 0 0000", outstanding,
               {err_overflow, err_dup, err_orphan, err_timeout});
    end
    tick();
    checks++;
    if (retire_v !== 1'b0) begin
      failures++;
      $display("FAIL basic_pulse got=%b expected=0", retire_v);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      set_req(11'd2, 12'(i));
      tick();
    end
    checks++;
    if (outstanding !== 5'd16 || full !== 1'b1 || err_overflow !== 1'b0) begin
      failures++;
      $display("FAIL full_16 out=%0d full=%b ovf=%b expected 16 1 0", outstanding, full, err_overflow);
    end
    set_req(11'd2, 12'd16);
    tick();
    checks++;
    if (outstanding !== 5'd16 || err_overflow !== 1'b1) begin
      failures++;
      $display("FAIL full_17th out=%0d ovf=%b expected 16 1", outstanding, err_overflow);
    end
    // Completion frees entry 3 but the same-cycle request still sees full
    set_rsp(11'd2, 12'd3, 5'h04);
    set_req(11'd2, 12'h020);
    tick();
    checks++;
    if (outstanding !== 5'd15 || full !== 1'b0 || retire_v !== 1'b1 || retire_txnid !== 12'd3) begin
      failures++;
      $display("FAIL full_samecyc out=%0d full=%b rv=%b txn=%h expected 15 0 1 003",
               outstanding, full, retire_v, retire_txnid);
    end
    set_req(11'd2, 12'h020);
    tick();
    checks++;
    if (outstanding !== 5'd16 || full !== 1'b1 || err_dup !== 1'b0) begin
      failures++;
      $display("FAIL full_reuse out=%0d full=%b dup=%b expected 16 1 0", outstanding, full, err_dup);
    end
  endtask

  task automatic test_dup_orphan();
    do_reset();
    set_req(11'd1, 12'd7);
    tick();
    set_req(11'd1, 12'd7);
    tick();
    checks++;
    if (err_dup !== 1'b1 || outstanding !== 5'd1) begin
      failures++;
      $display("FAIL dup got dup=%b out=%0d expected 1 1", err_dup, outstanding);
    end
    set_rsp(11'd1, 12'd7, 5'h05);
    tick();
    checks++;
    if (retire_v !== 1'b1 || outstanding !== 5'd0 || err_orphan !== 1'b0) begin
      failures++;
      $display("FAIL dup_retire rv=%b out=%0d orph=%b expected 1 0 0", retire_v, outstanding, err_orphan);
    end
    set_rsp(11'd1, 12'd7, 5'h03);
    tick();
    checks++;
    if (err_orphan !== 1'b1 || retire_v !== 1'b0) begin
      failures++;
      $display("FAIL orphan got orph=%b rv=%b expected 1 0", err_orphan, retire_v);
    end
    clear_err = 1'b1;
    tick();
    checks++;
    if ({err_overflow, err_dup, err_orphan} !== 3'b0) begin
      failures++;
      $display("FAIL clear got=%b expected=000", {err_overflow, err_dup, err_orphan});
    end
  endtask

  task automatic test_timeout();
    do_reset();
    set_req(11'd0, 12'h003);
    tick();
    set_req(11'd0, 12'h004);
    tick();
    ticks(6);
    checks++;
    if (t_err_timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_early got=%b expected=0", t_err_timeout);
    end
    tick();
    checks++;
    if (t_err_timeout !== 1'b1 || t_timeout_txnid !== 12'h003) begin
      failures++;
      $display("FAIL timeout_hit got=%b txn=%h expected 1 003", t_err_timeout, t_timeout_txnid);
    end
    tick();
    checks++;
    if (t_timeout_txnid !== 12'h003 || err_timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_first got txn=%h long=%b expected 003 0", t_timeout_txnid, err_timeout);
    end
    set_rsp(11'd0, 12'h003, 5'h04);
    tick();
    checks++;
    if (t_retire_v !== 1'b1 || t_retire_age !== 16'd10 || t_err_orphan !== 1'b0 ||
        t_outstanding !== 5'd1) begin
      failures++;
      $display("FAIL timeout_retire rv=%b age=%0d orph=%b out=%0d expected 1 10 0 1",
               t_retire_v, t_retire_age, t_err_orphan, t_outstanding);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    set_req(11'd3, 12'h055);
    set_rsp(11'd3, 12'h055, 5'h04);
    tick();
    checks++;
    if (err_orphan !== 1'b1 || outstanding !== 5'd1 || retire_v !== 1'b0) begin
      failures++;
      $display("FAIL same_cyc orph=%b out=%0d rv=%b expected 1 1 0", err_orphan, outstanding, retire_v);
    end
    clear_err = 1'b1;
    tick();
    set_rsp(11'd3, 12'h055, 5'h06);
    tick();
    checks++;
    if (retire_v !== 1'b0 || outstanding !== 5'd1 || err_orphan !== 1'b0) begin
      failures++;
      $display("FAIL dbidresp rv=%b out=%0d orph=%b expected 0 1 0", retire_v, outstanding, err_orphan);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_req(11'd4, 12'(8'h40 + i));
      tick();
    end
    set_req(11'd4, 12'h040);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (outstanding !== 5'd0 || err_dup !== 1'b0 || full !== 1'b0) begin
      failures++;
      $display("FAIL async_reset out=%0d dup=%b full=%b expected 0 0 0", outstanding, err_dup, full);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_req(11'd9, 12'h077);
    tick();
    checks++;
    if (outstanding !== 5'd1) begin
      failures++;
      $display("FAIL post_reset_alloc got=%0d expected=1", outstanding);
    end
    set_req(11'd9, 12'h077);
    tick();
    clear_err = 1'b1;
    set_rsp(11'd9, 12'h099, 5'h04);
    tick();
    checks++;
    if (err_orphan !== 1'b1 || err_dup !== 1'b0) begin
      failures++;
      $display("FAIL clear_vs_orphan orph=%b dup=%b expected 1 0", err_orphan, err_dup);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_dup_orphan();
    test_timeout();
    test_same_cycle();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/chi_txn_tracker.md
# chi_txn_tracker

Parametrised CHI request/response transaction tracker for the RN-side protocol monitor. Records each valid TXREQ flit in a DEPTH-entry table keyed by (SrcID, TxnID) and retires it on the matching RXRSP completion. Checks for overflow, duplicate TxnIDs, orphan responses and per-entry timeout, and reports each retirement with its latency. Sits beside the flit-field decoder and watches the same TX/RX channel wires passively.

## Interface

- DEPTH, 16: table entries, power of two, 2..64
- NODEID_W, 11: SrcID/TgtID width
- TXNID_W, 12: TxnID width
- REQ_W, 154: TXREQ flit width
- RSP_W, 73: RXRSP flit width
- TIMEOUT, 1024: cycles before an outstanding entry is flagged, 2..65535
- AGE_W, 16: age counter width, must satisfy 2^AGE_W > TIMEOUT

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_flitv  in  1  TXREQFLITV
- req_flit  in  REQ_W  TXREQFLIT; SrcID [25:15], TxnID [37:26]
- rsp_flitv  in  1  RXRSPFLITV
- rsp_flit  in  RSP_W  RXRSPFLIT; TgtID [14:4], TxnID [37:26], Opcode [42:38]
- clear_err  in  1  synchronous clear of all sticky error flags
- outstanding  out  $clog2(DEPTH)+1  valid entry count
- full  out  1  outstanding == DEPTH
- retire_v  out  1  one-cycle pulse, an entry retired
- retire_txnid  out  TXNID_W  TxnID of retired entry
- retire_age  out  AGE_W  cycles from allocation to retirement
- err_overflow  out  1  sticky, request seen while full
- err_dup  out  1  sticky, request duplicates a live (SrcID, TxnID)
- err_orphan  out  1  sticky, completion with no matching entry
- err_timeout  out  1  sticky, an entry's age reached TIMEOUT
- timeout_txnid  out  TXNID_W  TxnID of the first timed-out entry since the last clear

## Operation

- Each entry holds valid, srcid, txnid, age[AGE_W], tflag. Reset clears all entries and drives every output to 0.
- **Allocate.** A req_flitv cycle is checked against the pre-edge table.
  - Duplicate: some valid entry has equal (srcid, txnid). Set err_dup and drop the request.
  - Full: otherwise, if full, set err_overflow and drop the request.
  - Otherwise write the lowest-index free entry with age=0, tflag=0.
- **Retire.** A rsp_flitv cycle whose Opcode is Comp (0x04), CompDBIDResp (0x05) or RetryAck (0x03) searches the pre-edge table for a valid entry with srcid==TgtID and txnid==TxnID.
  - On a hit: clear that entry. Pulse retire_v with retire_txnid and retire_age = the entry's age + 1.
  - On a miss: set err_orphan.
  - All other opcodes are ignored.
- Only one entry can match, because duplicates are refused.
- **Age.** Each valid entry increments age every cycle, saturating at all-ones.
  - When age+1 == TIMEOUT and tflag==0: set tflag and err_timeout.
  - If err_timeout was 0 before that edge, load timeout_txnid. If several entries cross on the same edge, load the lowest index.
  - The entry stays valid and can still retire.
- **Simultaneous events.**
  - Request and completion in the same cycle are handled independently against the pre-edge table.
  - A completion matching a request presented in the same cycle is orphan.
  - A completion that frees the only slot while full does not admit a same-cycle request: it is an overflow.
  - A slot freed this cycle is reusable next cycle.
- clear_err zeroes all err_* flags and timeout_txnid. An error event in the same cycle as clear_err wins: the flag is set.
- outstanding is updated as +1 for an allocation and −1 for a retirement, both in the same edge; full is derived from the registered count.

## Timing

- All outputs are registered.
- Latency from a flit's valid cycle to its table, count, error or retire effect is 1 clock.
- No backpressure: the block never stalls the interface.
- The flags are sticky: they hold until clear_err or reset.
- retire_v is high for exactly one cycle per retirement.
- Reset asserted mid-operation empties the table asynchronously. The first request after deassertion allocates entry 0.

## Test plan

- Request SrcID=5, TxnID=0x12 at cycle 0, then Comp with TgtID=5, TxnID=0x12 at cycle 10 -> retire_v at cycle 11 with retire_txnid=0x12, retire_age=10; outstanding goes 1 then 0; no errors.
- DEPTH=16 distinct requests, then a 17th -> full=1, err_overflow=1, outstanding=16. A same-cycle Comp for entry 3 plus a new request -> request dropped, outstanding=15.
- Two requests SrcID=1, TxnID=7 on consecutive cycles -> err_dup=1, outstanding=1. One Comp retires it; a second Comp -> err_orphan=1.
- TIMEOUT=8: request TxnID=0x3 with no response -> err_timeout=1 and timeout_txnid=0x3 at cycle 8 after allocation. A later Comp -> retire_age=age+1, no orphan.
- Request and matching Comp in the same cycle -> err_orphan=1, entry allocated. A DBIDResp (0x06) for it -> no retire, no error.
- rst_n low for 1 cycle with 5 entries live -> outstanding=0 and all flags 0 immediately; the next request takes entry 0. clear_err coincident with a new orphan -> err_orphan stays 1.
